// File: rtl/latch_array_wr_sched.sv
// latch_array_wr_sched: round-robin write scheduler driving a negative-edge-enable latch array (clk/rst = nvdla_core_clk/nvdla_core_rst; req_* requester side, lat_en/lat_d array side, busy status)
module latch_array_wr_sched #(
  parameter int NREQ  = 2,
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 32
) (
  input  logic               nvdla_core_clk,
  input  logic               nvdla_core_rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    req_done,
  output logic [NREQ-1:0]    req_err,
  output logic [DEPTH-1:0]   lat_en,
  output logic [DW-1:0]      lat_d,
  output logic               busy
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] rr_q, rr_d, id_q, gid, c;
  logic [AW-1:0] addr_q;
  logic gnt, open, oor;
  always_comb begin
    gid = '0;
    gnt = 1'b0;
    c   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      c = IW'((int'(rr_q) + k) % NREQ);
      if (req_valid[c]) begin
        gid = c;
        gnt = 1'b1;
      end
    end
  end
  assign open      = (state_q == IDLE) || (state_q == HOLD);
  assign req_ready = (open && gnt) ? NREQ'(1) << gid : '0;
  assign state_d   = open ? (gnt ? SETUP : IDLE) : (state_q == SETUP ? PULSE : HOLD);
  assign rr_d      = (open && gnt) ? IW'((int'(gid) + 1) % NREQ) : rr_q;
  assign oor       = int'(addr_q) >= DEPTH;
  assign busy      = state_q != IDLE;
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      lat_en   <= '0;
      req_done <= '0;
      req_err  <= '0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      lat_en   <= (state_q == SETUP && !oor) ? DEPTH'(1) << addr_q : '0;
      req_done <= (state_q == PULSE) ? NREQ'(1) << id_q : '0;
      req_err  <= (state_q == PULSE && oor) ? NREQ'(1) << id_q : '0;
    end
  end
  // Data lands on the bus at the grant edge so it is settled a full cycle before EN rises.
  always_ff @(posedge nvdla_core_clk) begin
    if (open && gnt && !nvdla_core_rst) begin
      addr_q <= req_addr[gid*AW +: AW];
      id_q   <= gid;
      lat_d  <= req_data[gid*DW +: DW];
    end
  end
endmodule
